ps2_dirn_receiver: RTL and testbench

PS/2 keyboard receiver and scan-code decoder for the snake game. It takes the open-collector PS/2 clock and data lines from the keyboard and deserializes 11-bit frames. It then decodes Set-2 scan codes into the same 2-bit direction code and one-cycle SCEN strobes that the button debouncers produce, so the arrow keys and Enter/Space can drive the length and state-machine blocks alongside or instead of BtnU/D/L/R/C.

---
 rtl/ps2_dirn_receiver.sv | 120 ++++++++++++
 tb/tb_ps2_dirn_receiver.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_dirn_receiver.sv
// ps2_dirn_receiver: PS/2 keyboard frame receiver with Set-2 decode into direction and
// acknowledge strobes matching the button debouncers.
module ps2_dirn_receiver #(
  parameter int FILTER_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       PS2_Clk,
  input  logic       PS2_Data,
  output logic [7:0] Rx_Byte,
  output logic       Rx_Valid,
  output logic       Frame_Err,
  output logic [1:0] In_Dirn,
  output logic       Dirn_SCEN,
  output logic       Ack_SCEN
);
  localparam int FW = $clog2(FILTER_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] F_LAST = FW'(FILTER_CYCLES - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  typedef enum logic {IDLE, RECV} frame_t;
  typedef enum logic [1:0] {BASE, EXT, BRK, EXT_BRK} dec_t;
  logic [1:0] clk_s, dat_s;
  logic [FW-1:0] flt_cnt;
  logic filt, filt_d, fall, dat;
  frame_t f_st, f_nx;
  logic [3:0] bit_cnt;
  logic [7:0] sr;
  logic par, good, bad;
  logic [TW-1:0] idle_cnt;
  dec_t d_st, d_nx;
  logic dirn_hit, ack_hit;
  logic [1:0] dirn_nx;
  // Idle PS/2 lines are high, so synchronizers and the filtered clock reset to 1.
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      clk_s <= 2'b11;
      dat_s <= 2'b11;
      flt_cnt <= '0;
      filt <= 1'b1;
      filt_d <= 1'b1;
    end else begin
      clk_s <= {clk_s[0], PS2_Clk};
      dat_s <= {dat_s[0], PS2_Data};
      filt_d <= filt;
      if (clk_s[1] == filt) flt_cnt <= '0;
      else if (flt_cnt == F_LAST) begin
        filt <= clk_s[1];
        flt_cnt <= '0;
      end else flt_cnt <= flt_cnt + 1'b1;
    end
  assign fall = filt_d & ~filt;
  assign dat = dat_s[1];
  always_comb begin
    f_nx = f_st;
    good = 1'b0;
    bad = 1'b0;
    if (f_st == IDLE) f_nx = (fall && !dat) ? RECV : IDLE;
    else if (fall && bit_cnt == 4'd10) begin
      f_nx = IDLE;
      good = (^{sr, par}) & dat;
      bad = ~good;
    end else if (!fall && idle_cnt == T_LAST) begin
      f_nx = IDLE;
      bad = 1'b1;
    end
  end
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      f_st <= IDLE;
      bit_cnt <= '0;
      sr <= '0;
      par <= 1'b0;
      idle_cnt <= '0;
      Rx_Byte <= '0;
      Rx_Valid <= 1'b0;
      Frame_Err <= 1'b0;
    end else begin
      f_st <= f_nx;
      Rx_Valid <= good;
      Frame_Err <= bad;
      if (good) Rx_Byte <= sr;
      bit_cnt <= (f_nx == IDLE) ? '0 : bit_cnt + {3'b0, fall};
      idle_cnt <= (f_st == IDLE || fall) ? '0 : idle_cnt + 1'b1;
      if (fall && f_st == RECV && bit_cnt <= 4'd8) sr <= {dat, sr[7:1]};
      if (fall && f_st == RECV && bit_cnt == 4'd9) par <= dat;
    end
  always_comb begin
    d_nx = d_st;
    dirn_hit = 1'b0;
    ack_hit = 1'b0;
    dirn_nx = Rx_Byte == 8'h75 ? 2'b00 : Rx_Byte == 8'h72 ? 2'b01 : Rx_Byte == 8'h6B ? 2'b10 : 2'b11;
    if (Frame_Err) d_nx = BASE;
    else if (Rx_Valid)
      case (d_st)
        BASE: begin
          d_nx = Rx_Byte == 8'hE0 ? EXT : Rx_Byte == 8'hF0 ? BRK : BASE;
          ack_hit = Rx_Byte == 8'h5A || Rx_Byte == 8'h29;
        end
        EXT: begin
          d_nx = Rx_Byte == 8'hF0 ? EXT_BRK : Rx_Byte == 8'hE0 ? EXT : BASE;
          dirn_hit = Rx_Byte inside {8'h75, 8'h72, 8'h6B, 8'h74};
        end
        default: d_nx = BASE;
      endcase
  end
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      d_st <= BASE;
      In_Dirn <= 2'b00;
      Dirn_SCEN <= 1'b0;
      Ack_SCEN <= 1'b0;
    end else begin
      d_st <= d_nx;
      Dirn_SCEN <= dirn_hit;
      Ack_SCEN <= ack_hit;
      if (dirn_hit) In_Dirn <= dirn_nx;
    end
endmodule

// File: tb/tb_ps2_dirn_receiver.sv
// tb_ps2_dirn_receiver: vector table, randomized frames against a prefix-queue model,
// and hand sequences for reset, timeout and glitch behaviour.
module tb_ps2_dirn_receiver;
  localparam int F = 8;
  localparam int T = 20000;
  localparam int HALF = 20;
  logic Clk = 1'b0, Reset_n = 1'b0, PS2_Clk = 1'b1, PS2_Data = 1'b1;
  logic [7:0] Rx_Byte;
  logic Rx_Valid, Frame_Err, Dirn_SCEN, Ack_SCEN;
  logic [1:0] In_Dirn;
  ps2_dirn_receiver #(.FILTER_CYCLES(F), .TIMEOUT_CYCLES(T)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .PS2_Clk(PS2_Clk), .PS2_Data(PS2_Data),
    .Rx_Byte(Rx_Byte), .Rx_Valid(Rx_Valid), .Frame_Err(Frame_Err),
    .In_Dirn(In_Dirn), .Dirn_SCEN(Dirn_SCEN), .Ack_SCEN(Ack_SCEN)
  );
  always #5 Clk = ~Clk;
  int checks = 0, errors = 0, cyc = 0, t_fall = 0, t_err = 0;
  int n_valid = 0, n_err = 0, n_dirn = 0, n_ack = 0;
  logic prev_valid = 1'b0;
  logic [1:0] prev_dirn = 2'b00;
  logic [7:0] pfx[$];
  logic [7:0] m_byte = 8'h00;
  logic [1:0] m_dirn = 2'b00;
  logic [7:0] arrows [4] = '{8'h75, 8'h72, 8'h6B, 8'h74};
  logic [7:0] codes [9] = '{8'hE0, 8'hF0, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h5A, 8'h29, 8'hAA};
  typedef struct {
    logic [7:0] b;
    bit pb, sb, v, e, d, a;
    logic [7:0] eb;
    logic [1:0] ed;
  } vec_t;
  vec_t tbl [23];
  always @(posedge Clk) cyc++;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  // Strobe bookkeeping and cycle-level relations between strobes.
  always @(negedge Clk) begin
    if (Reset_n) begin
      if (Rx_Valid) n_valid++;
      if (Rx_Valid) chk("valid_err_exclusive", int'(Frame_Err), 0);
      if (Frame_Err) begin
        n_err++;
        t_err = cyc;
      end
      if (Dirn_SCEN) begin
        n_dirn++;
        chk("dirn_one_after_valid", int'(prev_valid), 1);
      end
      if (Ack_SCEN) begin
        n_ack++;
        chk("ack_one_after_valid", int'(prev_valid), 1);
      end
      if (In_Dirn != prev_dirn) chk("in_dirn_changes_with_scen", int'(Dirn_SCEN), 1);
    end
    prev_valid = Rx_Valid;
    prev_dirn = In_Dirn;
  end
  task automatic tick(input int n);
    repeat (n) @(negedge Clk);
  endtask
  function automatic logic [10:0] frame_bits(input logic [7:0] b, input bit pb, input bit sb);
    return {~sb, (~^b) ^ pb, b, 1'b0};
  endfunction
  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      PS2_Data = bits[i];
      tick(HALF);
      PS2_Clk = 1'b0;
      t_fall = cyc;
      tick(HALF);
      PS2_Clk = 1'b1;
    end
  endtask
  task automatic send_frame(input logic [7:0] b, input bit pb, input bit sb);
    send_bits(frame_bits(b, pb, sb), 11);
    PS2_Data = 1'b1;
    tick(30);
  endtask
  // Reference: pending prefix bytes kept in a queue; a byte after F0 is always swallowed.
  task automatic model(input logic [7:0] b, input bit ok, output bit v, output bit e, output bit d, output bit a);
    v = ok;
    e = !ok;
    d = 0;
    a = 0;
    if (!ok) pfx.delete();
    else begin
      m_byte = b;
      if (pfx.size() > 0 && pfx[pfx.size()-1] == 8'hF0) pfx.delete();
      else if (pfx.size() > 0) begin
        if (b == 8'hF0) pfx.push_back(b);
        else if (b != 8'hE0) begin
          for (int k = 0; k < 4; k++)
            if (arrows[k] == b) begin
              d = 1;
              m_dirn = 2'(k);
            end
          pfx.delete();
        end
      end else if (b == 8'hE0 || b == 8'hF0) pfx.push_back(b);
      else a = (b == 8'h5A || b == 8'h29);
    end
  endtask
  task automatic run_frame(input string tag, input logic [7:0] b, input bit pb, input bit sb,
                           input bit ev, input bit ee, input bit ed, input bit ea,
                           input logic [7:0] eb, input logic [1:0] edir);
    int v0, e0, d0, a0;
    v0 = n_valid; e0 = n_err; d0 = n_dirn; a0 = n_ack;
    send_frame(b, pb, sb);
    chk({tag, ".valid"}, n_valid - v0, int'(ev));
    chk({tag, ".err"}, n_err - e0, int'(ee));
    chk({tag, ".dirn_scen"}, n_dirn - d0, int'(ed));
    chk({tag, ".ack_scen"}, n_ack - a0, int'(ea));
    chk({tag, ".rx_byte"}, int'(Rx_Byte), int'(eb));
    chk({tag, ".in_dirn"}, int'(In_Dirn), int'(edir));
  endtask
  task automatic mframe(input string tag, input logic [7:0] b, input bit pb, input bit sb);
    bit v, e, d, a;
    model(b, !(pb || sb), v, e, d, a);
    run_frame(tag, b, pb, sb, v, e, d, a, m_byte, m_dirn);
  endtask
  initial begin
    int v0, e0, d0, a0, lat, tf;
    bit v, e, d, a;
    tbl[0]  = '{8'h1C, 0, 0, 1, 0, 0, 0, 8'h1C, 2'd0};
    tbl[1]  = '{8'hE0, 0, 0, 1, 0, 0, 0, 8'hE0, 2'd0};
    tbl[2]  = '{8'h74, 0, 0, 1, 0, 1, 0, 8'h74, 2'd3};
    tbl[3]  = '{8'hE0, 0, 0, 1, 0, 0, 0, 8'hE0, 2'd3};
    tbl[4]  = '{8'hF0, 0, 0, 1, 0, 0, 0, 8'hF0, 2'd3};
    tbl[5]  = '{8'h75, 0, 0, 1, 0, 0, 0, 8'h75, 2'd3};
    tbl[6]  = '{8'hE0, 0, 0, 1, 0, 0, 0, 8'hE0, 2'd3};
    tbl[7]  = '{8'h72, 0, 0, 1, 0, 1, 0, 8'h72, 2'd1};
    tbl[8]  = '{8'h5A, 1, 0, 0, 1, 0, 0, 8'h72, 2'd1};
    tbl[9]  = '{8'h29, 0, 0, 1, 0, 0, 1, 8'h29, 2'd1};
    tbl[10] = '{8'hF0, 0, 0, 1, 0, 0, 0, 8'hF0, 2'd1};
    tbl[11] = '{8'h5A, 0, 0, 1, 0, 0, 0, 8'h5A, 2'd1};
    tbl[12] = '{8'hAA, 0, 0, 1, 0, 0, 0, 8'hAA, 2'd1};
    tbl[13] = '{8'hFA, 0, 0, 1, 0, 0, 0, 8'hFA, 2'd1};
    tbl[14] = '{8'hE0, 0, 0, 1, 0, 0, 0, 8'hE0, 2'd1};
    tbl[15] = '{8'hE0, 0, 0, 1, 0, 0, 0, 8'hE0, 2'd1};
    tbl[16] = '{8'h6B, 0, 0, 1, 0, 1, 0, 8'h6B, 2'd2};
    tbl[17] = '{8'hE0, 0, 0, 1, 0, 0, 0, 8'hE0, 2'd2};
    tbl[18] = '{8'h29, 0, 1, 0, 1, 0, 0, 8'hE0, 2'd2};
    tbl[19] = '{8'h75, 0, 0, 1, 0, 0, 0, 8'h75, 2'd2};
    tbl[20] = '{8'h5A, 0, 0, 1, 0, 0, 1, 8'h5A, 2'd2};
    tbl[21] = '{8'hE0, 0, 0, 1, 0, 0, 0, 8'hE0, 2'd2};
    tbl[22] = '{8'h75, 0, 0, 1, 0, 1, 0, 8'h75, 2'd0};
    tick(3);
    chk("reset.rx_byte", int'(Rx_Byte), 0);
    chk("reset.rx_valid", int'(Rx_Valid), 0);
    chk("reset.frame_err", int'(Frame_Err), 0);
    chk("reset.in_dirn", int'(In_Dirn), 0);
    chk("reset.dirn_scen", int'(Dirn_SCEN), 0);
    chk("reset.ack_scen", int'(Ack_SCEN), 0);
    Reset_n = 1'b1;
    tick(5);
    for (int i = 0; i < 23; i++) begin
      model(tbl[i].b, !(tbl[i].pb || tbl[i].sb), v, e, d, a);
      run_frame($sformatf("tbl%0d", i), tbl[i].b, tbl[i].pb, tbl[i].sb,
                tbl[i].v, tbl[i].e, tbl[i].d, tbl[i].a, tbl[i].eb, tbl[i].ed);
    end
    for (int i = 0; i < 40; i++) begin
      logic [7:0] b;
      int r;
      r = $urandom_range(0, 9);
      b = (r < 9) ? codes[r] : 8'($urandom_range(0, 255));
      mframe($sformatf("rnd%0d", i), b, $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0);
    end
    mframe("pre_reset_e0", 8'hE0, 0, 0);
    mframe("pre_reset_74", 8'h74, 0, 0);
    send_bits(frame_bits(8'h3C, 0, 0), 5);
    Reset_n = 1'b0;
    PS2_Data = 1'b1;
    tick(3);
    chk("midrst.rx_byte", int'(Rx_Byte), 0);
    chk("midrst.in_dirn", int'(In_Dirn), 0);
    chk("midrst.valid", int'(Rx_Valid), 0);
    chk("midrst.err", int'(Frame_Err), 0);
    Reset_n = 1'b1;
    pfx.delete();
    m_byte = 8'h00;
    m_dirn = 2'b00;
    tick(5);
    mframe("post_reset_1c", 8'h1C, 0, 0);
    v0 = n_valid; e0 = n_err;
    send_bits(frame_bits(8'h3C, 0, 0), 4);
    tf = t_fall;
    PS2_Data = 1'b1;
    tick(25000);
    lat = t_err - tf;
    chk("timeout.err", n_err - e0, 1);
    chk("timeout.valid", n_valid - v0, 0);
    checks++;
    if (lat < T + F + 2 || lat > T + F + 4) begin
      errors++;
      $display("FAIL timeout.latency: got %0d expected %0d..%0d", lat, T + F + 2, T + F + 4);
    end
    pfx.delete();
    mframe("timeout_then_29", 8'h29, 0, 0);
    v0 = n_valid; e0 = n_err; d0 = n_dirn; a0 = n_ack;
    PS2_Clk = 1'b0;
    tick(5);
    PS2_Clk = 1'b1;
    tick(40);
    chk("glitch.valid", n_valid - v0, 0);
    chk("glitch.err", n_err - e0, 0);
    chk("glitch.dirn", n_dirn - d0, 0);
    chk("glitch.ack", n_ack - a0, 0);
    chk("glitch.rx_byte", int'(Rx_Byte), int'(m_byte));
    mframe("glitch_then_e0", 8'hE0, 0, 0);
    mframe("glitch_then_72", 8'h72, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
